// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the fetch/decode slice: widths, reset vector,
// major opcodes and the fetch FSM state type.
package rv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// In-order buffer of {pc, instr} entries with synchronous flush.
// Push into a full buffer and pop from an empty one are ignored here;
// the fetch unit's credit rule keeps push-when-full from happening.
module fetch_buffer #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push_i && (count_q != CW'(DEPTH));
  assign do_pop_s  = pop_i && (count_q != CW'(0));
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer/occupancy bookkeeping and entry storage; flush empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= W'(0);
      end
    end else if (flush_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Invariant checker for the fetch unit: no push into a full buffer, no more
// requests in flight than buffer entries, and never more words to drop than
// are actually outstanding.
module instr_fetch_unit_chk #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push_i,
  input logic [CW-1:0] count_i,
  input logic [CW-1:0] outstanding_i,
  input logic [CW-1:0] drop_cnt_i
);

  // A response must always find room in the buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (count_i == CW'(DEPTH))));

  // Credit rule bounds the in-flight count.
  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_i <= CW'(DEPTH));

  // Words to discard are a subset of words in flight; this also rules out underflow.
  a_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_i <= outstanding_i);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the IMEM request/response
// handshake, buffers returned words in order and hands them to decode with
// op/funct3 pre-split. Redirects flush the buffer and drop stale responses.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter  int              XLEN      = rv_pkg::XLEN,
  parameter  logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter  int              BUF_DEPTH = 2,
  localparam int              CW        = $clog2(BUF_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]      buf_count_s;
  logic [CW:0]        credit_used_s;
  logic               req_fire_s;
  logic               rsp_fire_s;
  logic               push_s;
  logic               pop_s;
  logic [XLEN-1:0]    target_aligned_s;
  logic [XLEN+31:0]   head_s;

  assign target_aligned_s = {redirect_target[XLEN-1:2], 2'b00};
  assign credit_used_s    = {1'b0, outstanding_q} + {1'b0, buf_count_s};

  // Issue gating: only while running, only with a free slot, never in a redirect cycle.
  assign imem_req_valid = (state_q == RUN) && (credit_used_s < (CW+1)'(BUF_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. from before a reset) are ignored.
  assign rsp_fire_s = imem_rsp_valid && (outstanding_q != CW'(0));
  assign push_s     = rsp_fire_s && (drop_cnt_q == CW'(0)) && !redirect_valid;
  assign pop_s      = instr_valid && instr_ready;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (XLEN + 32)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push_s),
    .push_data_i ({resp_pc_q, imem_rsp_data}),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (buf_count_s)
  );

  instr_fetch_unit_chk #(
    .DEPTH (BUF_DEPTH)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push_s),
    .count_i       (buf_count_s),
    .outstanding_i (outstanding_q),
    .drop_cnt_i    (drop_cnt_q)
  );

  // Decode-side view of the head entry; everything reads zero while empty.
  assign instr_valid    = (buf_count_s != CW'(0));
  assign instr          = instr_valid ? head_s[31:0] : 32'h0;
  assign instr_pc       = instr_valid ? head_s[XLEN+31:32] : XLEN'(0);
  assign instr_pc_plus4 = instr_valid ? (head_s[XLEN+31:32] + XLEN'(4)) : XLEN'(0);
  assign op             = instr[6:0];
  assign funct3         = instr[14:12];

  // Next-state logic: FSM, PCs and in-flight/drop accounting.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(rsp_fire_s);
    drop_cnt_d    = drop_cnt_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc_d = target_aligned_s;
      resp_pc_d  = target_aligned_s;
      drop_cnt_d = outstanding_q + CW'(req_fire_s) - CW'(rsp_fire_s);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end else begin
        resp_pc_d = resp_pc_q;
      end
      if (rsp_fire_s && (drop_cnt_q != CW'(0))) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // State register; reset abandons all in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= CW'(0);
      drop_cnt_q    <= CW'(0);
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule
